// File: rtl/tl_memory_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - ctrl_mem bit positions (branch, memory access, load extension, size)
//   - access size encoding (byte / half / word)
//   - ctrl_wb bit positions
//   - misalignment helper shared by the stage logic
package tl_memory_pkg;

  // ctrl_mem fields; bits [1:0] are reserved and ignored
  localparam int unsigned CM_BRANCH    = 8;
  localparam int unsigned CM_BRANCH_NE = 7;
  localparam int unsigned CM_MEM_READ  = 6;
  localparam int unsigned CM_MEM_WRITE = 5;
  localparam int unsigned CM_UNSIGNED  = 4;
  localparam int unsigned CM_SIZE_HI   = 3;
  localparam int unsigned CM_SIZE_LO   = 2;

  // ctrl_wb fields
  localparam int unsigned CW_REG_WRITE  = 1;
  localparam int unsigned CW_MEM_TO_REG = 0;

  // Size code 2'b11 also means word (only the upper bit selects word)
  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } mem_size_t;

  // True when the byte lane is illegal for the requested access size
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      default: bad = |lane;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/tl_memory_data_memory.sv
// data_memory: word-organised data RAM with per-byte write enables.
//   clk        write clock (rising edge)
//   rst_n      active-low reset; writes are blocked while low, contents kept
//   byte_en    one enable per byte lane of the addressed word
//   addr       word index
//   wdata      write data, already placed on the correct lanes
//   rdata      asynchronous read of the addressed word
// Optional (MEM_DEBUG_PORT_EN defined):
//   debug_addr / debug_data  second asynchronous read port for the debug unit
module data_memory
  import tl_memory_pkg::*;
#(
  parameter int unsigned LEN         = 32,
  parameter int unsigned NB_ADDR_MEM = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LEN/8-1:0]       byte_en,
  input  logic [NB_ADDR_MEM-1:0] addr,
  input  logic [LEN-1:0]         wdata,
  output logic [LEN-1:0]         rdata
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR_MEM-1:0] debug_addr,
  output logic [LEN-1:0]         debug_data
`endif
);

  logic [LEN-1:0] mem [2**NB_ADDR_MEM];

  // No reset on the array: reset only suppresses a write in flight
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned b = 0; b < LEN/8; b++) begin
        if (byte_en[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

`ifdef MEM_DEBUG_PORT_EN
  assign debug_data = mem[debug_addr];
`endif

endmodule

// File: rtl/tl_memory.sv
// tl_memory: MEM pipeline stage.
// Consumes the EX/MEM bundle, performs byte/half/word loads and stores on a
// little-endian data memory, resolves the branch decision, forwards the ALU
// value back to EX and registers the MEM/WB bundle on the falling clock edge.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_alu_result, i_dato2, i_alu_zero, i_pc_branch, i_ctrl_mem, i_ctrl_wb,
//   i_write_reg, i_halt                     -- EX/MEM inputs, debug freeze
//   o_pc_src, o_pc_branch, o_rd_mem_corto   -- combinational
//   o_read_data, o_alu_result, o_write_reg,
//   o_ctrl_wb, o_misaligned                 -- MEM/WB register
// Configuration macro MEM_DEBUG_PORT_EN adds i_debug_addr / o_debug_data,
// a combinational word read independent of the pipeline and i_halt.
// Lane logic assumes LEN = 32.
module tl_memory
  import tl_memory_pkg::*;
#(
  parameter int unsigned LEN                  = 32,
  parameter int unsigned NB_ADDRESS_REGISTROS = 5,
  parameter int unsigned NB_CTRL_WB           = 2,
  parameter int unsigned NB_CTRL_MEM          = 9,
  parameter int unsigned NB_ADDR_MEM          = 7
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [LEN-1:0]                  i_alu_result,
  input  logic [LEN-1:0]                  i_dato2,
  input  logic                            i_alu_zero,
  input  logic [LEN-1:0]                  i_pc_branch,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  input  logic                            i_halt,
  output logic                            o_pc_src,
  output logic [LEN-1:0]                  o_pc_branch,
  output logic [LEN-1:0]                  o_rd_mem_corto,
  output logic [LEN-1:0]                  o_read_data,
  output logic [LEN-1:0]                  o_alu_result,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic                            o_misaligned
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR_MEM-1:0]          i_debug_addr,
  output logic [LEN-1:0]                  o_debug_data
`endif
);

  logic                   branch, branch_ne, mem_read, mem_write, load_unsigned;
  mem_size_t              size;
  logic [1:0]             lane;
  logic [NB_ADDR_MEM-1:0] word_addr;
  logic                   misaligned;
  logic                   store_en;
  logic [LEN/8-1:0]       byte_en;
  logic [LEN-1:0]         store_data;
  logic [LEN-1:0]         mem_word;
  logic [LEN-1:0]         load_data;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;

  // Address bits above the memory depth and reserved ctrl bits are ignored
  logic unused_bits;
  assign unused_bits = ^{i_alu_result[LEN-1:NB_ADDR_MEM+2], i_ctrl_mem[1:0]};

  assign branch        = i_ctrl_mem[CM_BRANCH];
  assign branch_ne     = i_ctrl_mem[CM_BRANCH_NE];
  assign mem_read      = i_ctrl_mem[CM_MEM_READ];
  assign mem_write     = i_ctrl_mem[CM_MEM_WRITE];
  assign load_unsigned = i_ctrl_mem[CM_UNSIGNED];
  assign size          = mem_size_t'(i_ctrl_mem[CM_SIZE_HI:CM_SIZE_LO]);

  assign word_addr = i_alu_result[NB_ADDR_MEM+1:2];
  assign lane      = i_alu_result[1:0];

  assign o_pc_src       = (branch & i_alu_zero) | (branch_ne & ~i_alu_zero);
  assign o_pc_branch    = i_pc_branch;
  assign o_rd_mem_corto = i_alu_result;

  assign misaligned = (mem_read | mem_write) & is_misaligned(size, lane);
  assign store_en   = mem_write & ~misaligned & ~i_halt;

  // Replicate the store data across lanes; byte enables pick the real target
  always_comb begin
    store_data = i_dato2;
    byte_en    = '0;
    case (size)
      SZ_BYTE: begin
        store_data = {4{i_dato2[7:0]}};
        byte_en    = 4'b0001 << lane;
      end
      SZ_HALF: begin
        store_data = {2{i_dato2[15:0]}};
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = i_dato2;
        byte_en    = '1;
      end
    endcase
    if (!store_en) byte_en = '0;
  end

  data_memory #(
    .LEN         (LEN),
    .NB_ADDR_MEM (NB_ADDR_MEM)
  ) u_data_memory (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .byte_en    (byte_en),
    .addr       (word_addr),
    .wdata      (store_data),
    .rdata      (mem_word)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .debug_addr (i_debug_addr),
    .debug_data (o_debug_data)
`endif
  );

  assign byte_sel = mem_word[8*lane +: 8];
  assign half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data = '0;
    if (mem_read && !misaligned) begin
      case (size)
        SZ_BYTE: load_data = {{(LEN-8){byte_sel[7] & ~load_unsigned}}, byte_sel};
        SZ_HALF: load_data = {{(LEN-16){half_sel[15] & ~load_unsigned}}, half_sel};
        default: load_data = mem_word;
      endcase
    end
  end

  // MEM/WB register on the falling edge so a store on the preceding rising
  // edge is already visible to a load of the same word
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_write_reg  <= '0;
      o_ctrl_wb    <= '0;
      o_misaligned <= 1'b0;
    end else if (!i_halt) begin
      o_read_data  <= load_data;
      o_alu_result <= i_alu_result;
      o_write_reg  <= i_write_reg;
      o_ctrl_wb    <= i_ctrl_wb;
      o_misaligned <= misaligned;
    end
  end

endmodule

// File: tb/tb_tl_memory.sv
module tb_tl_memory;

  localparam logic [8:0] C_LW  = 9'b001001000;
  localparam logic [8:0] C_SW  = 9'b000101000;
  localparam logic [8:0] C_SB  = 9'b000100000;
  localparam logic [8:0] C_LB  = 9'b001000000;
  localparam logic [8:0] C_LBU = 9'b001010000;
  localparam logic [8:0] C_LH  = 9'b001000100;
  localparam logic [8:0] C_BEQ = 9'b100000000;
  localparam logic [8:0] C_BNE = 9'b010000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, dato2, pc_branch_in;
  logic        alu_zero, halt;
  logic [8:0]  ctrl_mem;
  logic [1:0]  ctrl_wb_in;
  logic [4:0]  write_reg_in;
  logic        pc_src;
  logic [31:0] pc_branch_out, rd_mem_corto, read_data, alu_result_out;
  logic [4:0]  write_reg_out;
  logic [1:0]  ctrl_wb_out;
  logic        misaligned;
`ifdef MEM_DEBUG_PORT_EN
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: flat byte array of 512 bytes plus expected MEM/WB state
  logic [7:0]  mem_model [512];
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_wreg;
  logic [1:0]  e_cwb;
  logic        e_mis;
  logic [31:0] saved;

  always #5 clk = ~clk;

  tl_memory #(
    .LEN                  (32),
    .NB_ADDRESS_REGISTROS (5),
    .NB_CTRL_WB           (2),
    .NB_CTRL_MEM          (9),
    .NB_ADDR_MEM          (7)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_alu_result   (alu_result),
    .i_dato2        (dato2),
    .i_alu_zero     (alu_zero),
    .i_pc_branch    (pc_branch_in),
    .i_ctrl_mem     (ctrl_mem),
    .i_ctrl_wb      (ctrl_wb_in),
    .i_write_reg    (write_reg_in),
    .i_halt         (halt),
    .o_pc_src       (pc_src),
    .o_pc_branch    (pc_branch_out),
    .o_rd_mem_corto (rd_mem_corto),
    .o_read_data    (read_data),
    .o_alu_result   (alu_result_out),
    .o_write_reg    (write_reg_out),
    .o_ctrl_wb      (ctrl_wb_out),
    .o_misaligned   (misaligned)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .i_debug_addr   (debug_addr),
    .o_debug_data   (debug_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
    int unsigned n    = nbytes(sz);
    int unsigned base = a % 512;
    logic [31:0] v    = '0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(mem_model[base + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int unsigned n    = nbytes(sz);
    int unsigned base = a % 512;
    for (int unsigned i = 0; i < n; i++) mem_model[base + i] = 8'(d >> (8 * i));
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_read_data"}, read_data, e_rd);
    check({tag, "_alu_result"}, alu_result_out, e_alu);
    check({tag, "_write_reg"}, 32'(write_reg_out), 32'(e_wreg));
    check({tag, "_ctrl_wb"}, 32'(ctrl_wb_out), 32'(e_cwb));
    check({tag, "_misaligned"}, 32'(misaligned), 32'(e_mis));
  endtask

  // One pipeline slot: drive after the falling edge, check combinational
  // outputs, then let the rising (store) and falling (capture) edges pass
  task automatic op(input logic [8:0] cm, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] cwb, input logic [4:0] wreg, input logic z,
                    input logic h, input logic [31:0] pcb);
    int unsigned n = nbytes(cm[3:2]);
    logic acc   = cm[6] | cm[5];
    logic mis   = acc && ((a % n) != 0);
    logic taken = (cm[8] && z) || (cm[7] && !z);
    ctrl_mem = cm; alu_result = a; dato2 = d; ctrl_wb_in = cwb;
    write_reg_in = wreg; alu_zero = z; halt = h; pc_branch_in = pcb;
    #1;
    check("pc_src", 32'(pc_src), 32'(taken));
    check("pc_branch", pc_branch_out, pcb);
    check("rd_mem_corto", rd_mem_corto, a);
    @(posedge clk);
    if (cm[5] && !mis && !h && rst) model_store(a, cm[3:2], d);
    @(negedge clk);
    #1;
    if (!rst) begin
      e_rd = '0; e_alu = '0; e_wreg = '0; e_cwb = '0; e_mis = 1'b0;
    end else if (!h) begin
      e_rd   = (cm[6] && !mis) ? model_load(a, cm[3:2], cm[4]) : 32'h0;
      e_alu  = a;
      e_wreg = wreg;
      e_cwb  = cwb;
      e_mis  = mis;
    end
    check_regs("step");
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; ctrl_mem = '0; alu_result = '0; dato2 = '0;
    ctrl_wb_in = '0; write_reg_in = '0; alu_zero = 1'b0; pc_branch_in = '0;
`ifdef MEM_DEBUG_PORT_EN
    debug_addr = '0;
`endif
    e_rd = '0; e_alu = '0; e_wreg = '0; e_cwb = '0; e_mis = 1'b0;

    // Asynchronous reset, observed before any clock edge
    #2 rst = 1'b0;
    #1 check_regs("reset");
    @(negedge clk); #1;
    rst = 1'b1;

    // Fill memory with known random words
    for (int unsigned w = 0; w < 128; w++) op(C_SW, 32'(w * 4), $urandom, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);

    // Word store then load; ctrl_wb and write_reg pass through
    op(C_SW, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);
    op(C_LW, 32'h10, 32'h0, 2'b11, 5'd9, 1'b0, 1'b0, 32'h0);
    check("t1_lw", read_data, 32'hDEADBEEF);
    check("t1_ctrl_wb", 32'(ctrl_wb_out), 32'h3);
    check("t1_write_reg", 32'(write_reg_out), 32'd9);

    // Byte store and sub-word loads
    op(C_SB, 32'h11, 32'h0000007F, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);
    op(C_LW, 32'h10, 32'h0, 2'b10, 5'd1, 1'b0, 1'b0, 32'h0);
    check("t2_lw", read_data, 32'hDEAD7FEF);
    op(C_LB, 32'h13, 32'h0, 2'b10, 5'd2, 1'b0, 1'b0, 32'h0);
    check("t2_lb", read_data, 32'hFFFFFFDE);
    op(C_LBU, 32'h13, 32'h0, 2'b10, 5'd3, 1'b0, 1'b0, 32'h0);
    check("t2_lbu", read_data, 32'h000000DE);
    op(C_LH, 32'h12, 32'h0, 2'b10, 5'd4, 1'b0, 1'b0, 32'h0);
    check("t2_lh", read_data, 32'hFFFFDEAD);

    // Branch resolution
    op(C_BEQ, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 1'b0, 32'h40);
    check("t3_beq_taken", 32'(pc_src), 32'd1);
    check("t3_pc_branch", pc_branch_out, 32'h40);
    op(C_BEQ, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 32'h40);
    check("t3_beq_not", 32'(pc_src), 32'd0);
    op(C_BNE, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 32'h40);
    check("t3_bne_taken", 32'(pc_src), 32'd1);
    op(C_BEQ | C_BNE, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 1'b0, 32'h40);
    check("t3_both", 32'(pc_src), 32'd1);

    // Misaligned store suppressed, misaligned load returns 0
    saved = model_load(32'h20, 2'b10, 1'b0);
    op(C_SW, 32'h22, 32'h12345678, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);
    check("t4_sw_mis", 32'(misaligned), 32'd1);
    op(C_LW, 32'h20, 32'h0, 2'b10, 5'd5, 1'b0, 1'b0, 32'h0);
    check("t4_mis_oneshot", 32'(misaligned), 32'd0);
    check("t4_unchanged", read_data, saved);
    op(C_LH, 32'h21, 32'h0, 2'b10, 5'd6, 1'b0, 1'b0, 32'h0);
    check("t4_lh_data", read_data, 32'h0);
    check("t4_lh_mis", 32'(misaligned), 32'd1);

    // Halt freezes outputs and blocks the store
    op(C_LW, 32'h10, 32'h0, 2'b11, 5'd7, 1'b0, 1'b0, 32'h0);
    saved = model_load(32'h30, 2'b10, 1'b0);
    op(C_SW, 32'h30, 32'hCAFEF00D, 2'b01, 5'd8, 1'b0, 1'b1, 32'h0);
    check("t5_halt_data", read_data, 32'hDEAD7FEF);
    check("t5_halt_alu", alu_result_out, 32'h10);
    check("t5_halt_wreg", 32'(write_reg_out), 32'd7);
    op(C_LW, 32'h30, 32'h0, 2'b10, 5'd1, 1'b0, 1'b0, 32'h0);
    check("t5_halt_nowrite", read_data, saved);

    // Reset between edges clears registers at once; store under reset blocked
    op(C_LW, 32'h10, 32'h0, 2'b11, 5'd7, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    e_rd = '0; e_alu = '0; e_wreg = '0; e_cwb = '0; e_mis = 1'b0;
    check_regs("t5_async_rst");
    saved = model_load(32'h34, 2'b10, 1'b0);
    op(C_SW, 32'h34, 32'h11112222, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    op(C_LW, 32'h34, 32'h0, 2'b10, 5'd2, 1'b0, 1'b0, 32'h0);
    check("t5_rst_nowrite", read_data, saved);

    // Address wrap: 0x200 aliases word 0
    op(C_SW, 32'h200, 32'hA5A55A5A, 2'b00, 5'd0, 1'b0, 1'b0, 32'h0);
    op(C_LW, 32'h0, 32'h0, 2'b10, 5'd3, 1'b0, 1'b0, 32'h0);
    check("t6_alias", read_data, 32'hA5A55A5A);
`ifdef MEM_DEBUG_PORT_EN
    debug_addr = 7'd0;
    #1 check("t6_debug", debug_data, 32'hA5A55A5A);
`endif

    // Randomized traffic against the byte-array model
    for (int unsigned k = 0; k < 300; k++) begin
      logic [8:0]  cm;
      logic [31:0] a;
      cm = 9'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      op(cm, a, $urandom, 2'($urandom), 5'($urandom), 1'($urandom),
         ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
